// File: rtl/ltc1865_pkg.sv
// rtl/ltc1865_pkg.sv - shared constants and state encoding for the LTC1865 responder
package ltc1865_pkg;

  localparam int         DATA_W     = 16;
  localparam int         CFG_OS_BIT = 6;
  localparam int         CFG_SD_BIT = 7;
  localparam logic [7:0] CFG_CH0    = 8'h80;
  localparam logic [7:0] CFG_CH1    = 8'hC0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - 2-FF synchronizer with registered previous value for rise/fall pulses
module spi_pin_sync #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_pin,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  logic [W-1:0] r_prev;

  // Reset to 1 so idle-high SCK/CS do not produce an edge out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
      r_prev <= '1;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/ltc1865_spi_responder.sv
// rtl/ltc1865_spi_responder.sv - SPI mode-3 responder emulating the LTC1865 one-frame pipeline
module ltc1865_spi_responder
  import ltc1865_pkg::*;
#(
  parameter int CONV_CLKS = 165,
  parameter int DATA_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sck,
  input  logic              i_scs,
  input  logic              i_sdi,
  output logic              o_sdo,
  input  logic [DATA_W-1:0] i_ch0_data,
  input  logic [DATA_W-1:0] i_ch1_data,
  output logic [7:0]        o_rx_cfg,
  output logic              o_rx_dv,
  output logic              o_busy,
  output logic              o_frame_err,
  output logic              o_conv_err
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int IW = $clog2(DATA_W);
  localparam int TW = $clog2(CONV_CLKS);

  logic [2:0] w_sync, w_rise, w_fall;
  logic [2:0] w_unused_pins;
  logic       w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall, w_sdi, w_sync_ok;

  state_t              r_state, w_state_nxt;
  logic                r_armed;
  logic [1:0]          r_sync_cnt;
  logic [CW-1:0]       r_bit_cnt;
  logic [7:0]          r_rx_sreg;
  logic [DATA_W-1:0]   r_tx_sreg, r_result, r_snapshot, w_load_word;
  logic [TW-1:0]       r_timer;
  logic [IW-1:0]       w_tx_idx;
  logic [7:0]          r_rx_cfg;
  logic                r_sdo, r_rx_dv, r_frame_err, r_conv_err;
  logic                w_start, w_done, w_accept, w_frame_err, w_conv_err;
  logic                w_shift_in, w_shift_out;

  spi_pin_sync #(.W(3)) u_pin_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pin   ({i_sck, i_scs, i_sdi}),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_sck_rise    = w_rise[2];
  assign w_sck_fall    = w_fall[2];
  assign w_cs_rise     = w_rise[1];
  assign w_cs_fall     = w_fall[1] & r_armed;
  assign w_sdi         = w_sync[0];
  assign w_unused_pins = {w_sync[2], w_rise[0], w_fall[0]};
  // The synchronizer outputs carry reset values for two cycles; arm only on a real CS-high sample.
  assign w_sync_ok     = (r_sync_cnt == 2'd2);
  assign w_load_word   = w_done ? r_snapshot : r_result;
  assign w_tx_idx      = IW'(DATA_W - 1) - r_bit_cnt[IW-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    w_frame_err = 1'b0;
    w_conv_err  = 1'b0;
    w_shift_in  = 1'b0;
    w_shift_out = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = SHIFT;
          w_start     = 1'b1;
        end
      end
      CONV: begin
        // A CS fall on the very cycle the timer expires still gets the fresh result.
        if (w_cs_fall) begin
          w_state_nxt = SHIFT;
          w_start     = 1'b1;
          if (r_timer == '0) w_done     = 1'b1;
          else               w_conv_err = 1'b1;
        end else if (r_timer == '0) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          if (r_bit_cnt == CW'(DATA_W)) begin
            w_accept    = 1'b1;
            w_state_nxt = CONV;
          end else begin
            w_frame_err = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_shift_in  = w_sck_rise;
          w_shift_out = w_sck_fall;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed     <= 1'b0;
      r_sync_cnt  <= 2'd0;
      r_bit_cnt   <= '0;
      r_rx_sreg   <= '0;
      r_tx_sreg   <= '0;
      r_result    <= '0;
      r_snapshot  <= '0;
      r_timer     <= '0;
      r_rx_cfg    <= CFG_CH0;
      r_sdo       <= 1'b0;
      r_rx_dv     <= 1'b0;
      r_frame_err <= 1'b0;
      r_conv_err  <= 1'b0;
    end else begin
      r_rx_dv     <= w_accept;
      r_frame_err <= w_frame_err;
      r_conv_err  <= w_conv_err;
      if (!w_sync_ok)           r_sync_cnt <= r_sync_cnt + 2'd1;
      if (w_sync_ok && w_sync[1]) r_armed  <= 1'b1;
      if (w_done)               r_result   <= r_snapshot;
      if (w_start) begin
        r_bit_cnt <= '0;
        r_tx_sreg <= w_load_word;
        r_sdo     <= w_load_word[DATA_W-1];
      end
      if (w_accept) begin
        r_rx_cfg   <= r_rx_sreg;
        r_snapshot <= r_rx_sreg[CFG_OS_BIT] ? i_ch1_data : i_ch0_data;
        r_timer    <= TW'(CONV_CLKS - 1);
      end else if (r_state == CONV && r_timer != '0) begin
        r_timer <= r_timer - TW'(1);
      end
      if (w_shift_in) begin
        if (r_bit_cnt < CW'(8))      r_rx_sreg <= {r_rx_sreg[6:0], w_sdi};
        if (r_bit_cnt != CW'(DATA_W)) r_bit_cnt <= r_bit_cnt + CW'(1);
      end
      if (w_shift_out) begin
        if (r_bit_cnt == CW'(DATA_W)) r_sdo <= 1'b0;
        else if (r_bit_cnt != '0)     r_sdo <= r_tx_sreg[w_tx_idx];
      end
    end
  end

  assign o_sdo       = r_sdo;
  assign o_rx_cfg    = r_rx_cfg;
  assign o_rx_dv     = r_rx_dv;
  assign o_busy      = (r_state == CONV);
  assign o_frame_err = r_frame_err;
  assign o_conv_err  = r_conv_err;

endmodule

// File: tb/tb_ltc1865_spi_responder.sv
// tb/tb_ltc1865_spi_responder.sv - randomized self-checking bench for the LTC1865 responder
module tb_ltc1865_spi_responder;
  import ltc1865_pkg::*;

  localparam int CONV_CLKS = 165;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b1;
  logic        scs = 1'b1;
  logic        sdi = 1'b0;
  logic [15:0] ch0 = '0;
  logic [15:0] ch1 = '0;
  logic        sdo, rx_dv, busy, frame_err, conv_err;
  logic [7:0]  rx_cfg;

  always #5 clk = ~clk;

  ltc1865_spi_responder #(.CONV_CLKS(CONV_CLKS), .DATA_W(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sck       (sck),
    .i_scs       (scs),
    .i_sdi       (sdi),
    .o_sdo       (sdo),
    .i_ch0_data  (ch0),
    .i_ch1_data  (ch1),
    .o_rx_cfg    (rx_cfg),
    .o_rx_dv     (rx_dv),
    .o_busy      (busy),
    .o_frame_err (frame_err),
    .o_conv_err  (conv_err)
  );

  int cyc = 0;
  int dv_cnt = 0, fe_cnt = 0, ce_cnt = 0, multi_cnt = 0;
  int busy_run = 0, last_busy = 0;
  int n_checks = 0, n_pass = 0;

  // Reference model: the word returned is whatever conversion completed before the frame began.
  logic [15:0] m_result, m_pend;
  logic [7:0]  m_cfg;
  bit          m_pend_valid;
  int          rise_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_dv) dv_cnt++;
    if (frame_err) fe_cnt++;
    if (conv_err) ce_cnt++;
    if (int'(rx_dv) + int'(frame_err) + int'(conv_err) > 1) multi_cnt++;
    if (busy) busy_run++;
    else begin
      if (busy_run != 0) last_busy = busy_run;
      busy_run = 0;
    end
  end

  initial begin
    repeat (99000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d, required finish earlier", cyc);
    $fatal(1);
  end

  task automatic wait_gap(input int g);
    while (cyc - rise_cyc < g) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] cfg, input int nsck, input int half,
                           output logic [31:0] bits, output logic [15:0] exp_word,
                           output bit exp_cerr);
    int gap;
    gap = cyc - rise_cyc;
    exp_cerr = 1'b0;
    if (m_pend_valid) begin
      if (gap >= CONV_CLKS) m_result = m_pend;
      else                  exp_cerr = 1'b1;
      m_pend_valid = 1'b0;
    end
    exp_word = m_result;
    bits = '0;
    scs = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nsck; i++) begin
      sck = 1'b0;
      sdi = (i < 8) ? cfg[7-i] : 1'($urandom);
      repeat (half) @(negedge clk);
      bits = {bits[30:0], sdo};
      sck = 1'b1;
      repeat (half) @(negedge clk);
    end
    scs = 1'b1;
    rise_cyc = cyc;
    if (nsck >= 16) begin
      m_pend = cfg[CFG_OS_BIT] ? ch1 : ch0;
      m_pend_valid = 1'b1;
      m_cfg = cfg;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    m_result = '0; m_pend_valid = 1'b0; m_cfg = CFG_CH0; rise_cyc = cyc;
    n_checks++; if (sdo !== 1'b0) $display("FAIL reset_sdo: got %b want 0", sdo); else n_pass++;
    n_checks++; if (rx_cfg !== 8'h80) $display("FAIL reset_cfg: got %h want 80", rx_cfg); else n_pass++;
    n_checks++; if ({rx_dv, busy, frame_err, conv_err} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {rx_dv, busy, frame_err, conv_err}); else n_pass++;
  endtask

  task automatic test_basic;
    logic [31:0] bits; logic [15:0] exp; bit ce; int dv0;
    ch1 = 16'hA5C3; ch0 = 16'($urandom);
    dv0 = dv_cnt;
    run_frame(CFG_CH1, 16, 4, bits, exp, ce);
    repeat (6) @(negedge clk);
    n_checks++; if (bits[15:0] !== 16'h0000) $display("FAIL first_word: got %h want 0000", bits[15:0]); else n_pass++;
    n_checks++; if (rx_cfg !== 8'hC0) $display("FAIL first_cfg: got %h want c0", rx_cfg); else n_pass++;
    n_checks++; if (dv_cnt - dv0 !== 1) $display("FAIL first_dv: got %0d pulses want 1", dv_cnt - dv0); else n_pass++;
    repeat (CONV_CLKS + 10) @(negedge clk);
    n_checks++; if (last_busy !== CONV_CLKS) $display("FAIL busy_len: got %0d want %0d", last_busy, CONV_CLKS); else n_pass++;
    ch0 = 16'h1234;
    run_frame(CFG_CH0, 16, 5, bits, exp, ce);
    repeat (6) @(negedge clk);
    n_checks++; if (bits[15:0] !== 16'hA5C3) $display("FAIL second_word: got %h want a5c3", bits[15:0]); else n_pass++;
    n_checks++; if (rx_cfg !== 8'h80) $display("FAIL second_cfg: got %h want 80", rx_cfg); else n_pass++;
  endtask

  task automatic test_conv_err;
    logic [31:0] bits; logic [15:0] exp; bit ce; int ce0;
    wait_gap(CONV_CLKS - 1);
    ch0 = 16'h3C3C; ce0 = ce_cnt;
    run_frame(CFG_CH0, 16, 4, bits, exp, ce);
    repeat (6) @(negedge clk);
    n_checks++; if (ce_cnt - ce0 !== 1) $display("FAIL conv_err_164: got %0d pulses want 1", ce_cnt - ce0); else n_pass++;
    n_checks++; if (bits[15:0] !== exp) $display("FAIL stale_word: got %h want %h", bits[15:0], exp); else n_pass++;
    wait_gap(CONV_CLKS);
    ce0 = ce_cnt; ch1 = 16'($urandom);
    run_frame(CFG_CH1, 16, 4, bits, exp, ce);
    repeat (6) @(negedge clk);
    n_checks++; if (ce_cnt - ce0 !== 0) $display("FAIL conv_err_165: got %0d pulses want 0", ce_cnt - ce0); else n_pass++;
    n_checks++; if (bits[15:0] !== exp) $display("FAIL fresh_word: got %h want %h", bits[15:0], exp); else n_pass++;
  endtask

  task automatic test_frame_err;
    logic [31:0] bits; logic [15:0] exp; bit ce; int fe0, dv0;
    wait_gap(170);
    fe0 = fe_cnt; dv0 = dv_cnt;
    run_frame(8'h40, 10, 4, bits, exp, ce);
    repeat (6) @(negedge clk);
    n_checks++; if (fe_cnt - fe0 !== 1) $display("FAIL frame_err: got %0d pulses want 1", fe_cnt - fe0); else n_pass++;
    n_checks++; if (dv_cnt - dv0 !== 0) $display("FAIL short_dv: got %0d pulses want 0", dv_cnt - dv0); else n_pass++;
    n_checks++; if (rx_cfg !== m_cfg) $display("FAIL short_cfg: got %h want %h", rx_cfg, m_cfg); else n_pass++;
    n_checks++; if (bits[9:0] !== exp[15:6]) $display("FAIL short_bits: got %h want %h", bits[9:0], exp[15:6]); else n_pass++;
    wait_gap(170);
    run_frame(CFG_CH0, 16, 4, bits, exp, ce);
    repeat (6) @(negedge clk);
    n_checks++; if (bits[15:0] !== exp) $display("FAIL after_short_word: got %h want %h", bits[15:0], exp); else n_pass++;
  endtask

  task automatic test_long_frame;
    logic [31:0] bits; logic [15:0] exp; bit ce; int dv0;
    wait_gap(170);
    ch1 = 16'hF00D; dv0 = dv_cnt;
    run_frame(CFG_CH1, 20, 5, bits, exp, ce);
    repeat (6) @(negedge clk);
    n_checks++; if (bits[19:4] !== exp) $display("FAIL long_word: got %h want %h", bits[19:4], exp); else n_pass++;
    n_checks++; if (bits[3:0] !== 4'h0) $display("FAIL long_tail: got %h want 0", bits[3:0]); else n_pass++;
    n_checks++; if (dv_cnt - dv0 !== 1) $display("FAIL long_dv: got %0d pulses want 1", dv_cnt - dv0); else n_pass++;
    n_checks++; if (rx_cfg !== 8'hC0) $display("FAIL long_cfg: got %h want c0", rx_cfg); else n_pass++;
  endtask

  task automatic test_reset_mid_shift;
    logic [31:0] bits; logic [15:0] exp; bit ce; int dv0, fe0;
    wait_gap(170);
    scs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sck = 1'b0; repeat (4) @(negedge clk);
      sck = 1'b1; repeat (4) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    m_result = '0; m_pend_valid = 1'b0; m_cfg = CFG_CH0;
    n_checks++; if (sdo !== 1'b0) $display("FAIL midrst_sdo: got %b want 0", sdo); else n_pass++;
    n_checks++; if (rx_cfg !== 8'h80) $display("FAIL midrst_cfg: got %h want 80", rx_cfg); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    dv0 = dv_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 16; i++) begin
      sck = 1'b0; sdi = 1'($urandom); repeat (4) @(negedge clk);
      sck = 1'b1; repeat (4) @(negedge clk);
    end
    scs = 1'b1; rise_cyc = cyc;
    repeat (8) @(negedge clk);
    n_checks++; if (dv_cnt - dv0 !== 0) $display("FAIL unarmed_dv: got %0d pulses want 0", dv_cnt - dv0); else n_pass++;
    n_checks++; if (fe_cnt - fe0 !== 0) $display("FAIL unarmed_ferr: got %0d pulses want 0", fe_cnt - fe0); else n_pass++;
    wait_gap(20);
    run_frame(CFG_CH0, 16, 4, bits, exp, ce);
    repeat (6) @(negedge clk);
    n_checks++; if (bits[15:0] !== 16'h0000) $display("FAIL midrst_word: got %h want 0000", bits[15:0]); else n_pass++;
    n_checks++; if (dv_cnt - dv0 !== 1) $display("FAIL midrst_dv: got %0d pulses want 1", dv_cnt - dv0); else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] bits; logic [15:0] exp; bit ce; int ce0, half, gap; logic [7:0] cfg;
    for (int f = 0; f < 122; f++) begin
      half = (f < 2) ? 250 : $urandom_range(4, 6);
      gap  = ($urandom_range(0, 9) == 0) ? $urandom_range(150, 170) : $urandom_range(CONV_CLKS, CONV_CLKS + 15);
      cfg  = 8'($urandom);
      cfg[CFG_SD_BIT] = 1'($urandom);
      wait_gap(gap);
      ch0 = 16'($urandom); ch1 = 16'($urandom);
      ce0 = ce_cnt;
      run_frame(cfg, 16, half, bits, exp, ce);
      repeat (6) @(negedge clk);
      n_checks++; if (bits[15:0] !== exp) $display("FAIL rand_word[%0d]: got %h want %h", f, bits[15:0], exp); else n_pass++;
      n_checks++; if (rx_cfg !== cfg) $display("FAIL rand_cfg[%0d]: got %h want %h", f, rx_cfg, cfg); else n_pass++;
      n_checks++; if (ce_cnt - ce0 !== int'(ce)) $display("FAIL rand_cerr[%0d]: got %0d want %0d", f, ce_cnt - ce0, ce); else n_pass++;
    end
    n_checks++; if (multi_cnt !== 0) $display("FAIL pulse_overlap: got %0d cycles want 0", multi_cnt); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_conv_err;
    test_frame_err;
    test_long_frame;
    test_reset_mid_shift;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
